scan7seg: RTL
=============

# scan7seg

Capture block for a multiplexed 7-segment display bus: it samples segment lines and one-hot digit strobes and rebuilds the BCD digit values. It reverses the board's BCD-to-segment decoding. Each digit is qualified for stability before capture, and once every digit position has been captured the block presents one complete frame through a valid/ack handshake. It sits beside the display driver in the MY8CPU I/O path, where the CPU or test logic uses it to read back displayed values.

## Interface
- NDIG, 4: number of multiplexed digit positions (1..8).
- STABLE, 4: consecutive cycles an (S, DIG) pair must hold before capture (2..255).
- CLK  in  1  system clock; everything is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- S  in  7  segment lines, active-high; S[6]=a … S[0]=g. '0' is 1111110 and '1' is 0110000, matching the board's decoder.
- DIG  in  NDIG  digit strobes, active-high, one-hot.
- FRAME_ACK  in  1  consumer acknowledges the frame.
- BCD_OUT  out  4*NDIG  frame digits; digit i is at [4i+3:4i]. Reset value is 0.
- ERR  out  NDIG  per-digit invalid-pattern flag for the frame. Reset value is 0.
- FRAME_VLD  out  1  frame available. Reset value is 0.
- OVR  out  1  sticky overrun flag. Reset value is 0.

## Operation
- Input stage:
  - S and DIG are registered into S_q and DIG_q every cycle.
  - CNT (8 bits) counts consecutive cycles where {S,DIG} equals {S_q,DIG_q}.
  - On any mismatch, CNT clears to 0.
- The capture FSM has two states, SAMPLE and HOLD. Reset enters SAMPLE.
- SAMPLE:
  - Capture happens when CNT == STABLE-1, {S,DIG} equals {S_q,DIG_q}, and DIG_q is exactly one-hot.
  - On capture, the decoded nibble is written to working slot i (the index of the set DIG_q bit), the slot's err bit is written, and got[i] is set. The FSM then goes to HOLD.
- HOLD: stays until {S,DIG} differs from {S_q,DIG_q}, then returns to SAMPLE. This prevents a held digit from being captured more than once.
- Non-one-hot DIG_q (all zero, or two or more bits set): no capture and CNT keeps counting, but that pair is never captured. This includes blanking intervals.
- Pattern decode:
  - Valid patterns are exactly the ten decoder codes for 0..9.
  - Any other pattern, including all-off, writes nibble 4'hF with err=1.
- Frame completion:
  - When got becomes all ones, the working slots and err bits are copied into BCD_OUT and ERR, got clears, and FRAME_VLD=1.
  - The copy happens in the same edge that the last slot is written. The copy uses the newly written last slot.
- Handshake:
  - FRAME_VLD stays high until a cycle with FRAME_ACK=1, then clears on that edge.
  - FRAME_ACK while FRAME_VLD=0 is ignored.
- Overrun: if a new frame completes while FRAME_VLD=1 and FRAME_ACK=0, the new frame overwrites BCD_OUT and ERR, FRAME_VLD stays 1, and OVR sets.
- OVR clears on the edge where FRAME_ACK=1 with FRAME_VLD=1.
- Simultaneous completion and ACK in the same edge: the new frame loads, FRAME_VLD stays 1, and OVR is not set (ACK wins the clear).
- Digits captured twice before the frame completes: the later capture overwrites the slot.
- RST at any time: clears CNT, got, the working slots, all outputs and the input registers, and forces SAMPLE. A partially collected frame is discarded.

## Timing
- Let a new (S,DIG) value be applied before edge 0 and held. Edge 0 loads S_q and DIG_q. CNT reaches STABLE-1 at edge STABLE-1. The capture write occurs at edge STABLE.
- If that capture completes a frame, FRAME_VLD and BCD_OUT are visible after edge STABLE, so total latency is STABLE+1 cycles from the input change.
- A change lasting fewer than STABLE+1 cycles is never captured.
- FRAME_VLD falls one cycle after FRAME_ACK is sampled high.
- No combinational path from inputs to outputs.

## Structure
- Package seg7_pkg holds:
  - SEG_DIGIT[0:9]: the ten 7-bit patterns, shared with the decoder so that encode and decode cannot diverge.
  - BCD_INVALID = 4'hF.
  - The state encoding SAMPLE/HOLD.
- Sub-module enc7seg: combinational 7-bit pattern to {err, 4-bit BCD} lookup, the inverse of the decoder, instantiated once on S_q.
- Everything else (input registers, counter, FSM, got mask, slot and output registers, handshake) lives in scan7seg.

## Test plan
- Clean frame: NDIG=4, STABLE=4, digits 0..3 show 3,1,4,1, each held 6 cycles.
  - Required: FRAME_VLD rises 5 cycles after digit 3 is applied, with BCD_OUT=16'h1413 and ERR=0.
- Glitch: a digit held only 3 cycles is not captured and FRAME_VLD does not rise. Holding it 5 cycles is captured.
- Invalid pattern: digit 2 shows 0000000.
  - Required: BCD_OUT[11:8]=4'hF, ERR=4'b0100, and the other digits decode normally.
- Strobe errors: DIG=0000 or 0011 held for 20 cycles produces no captures and got stays unchanged. Long hold on a valid digit produces exactly one capture.
- Overrun and handshake:
  - Two frames completing with no ACK: BCD_OUT equals the second frame and OVR=1.
  - ACK: FRAME_VLD=0 and OVR=0 on the next cycle.
  - ACK coincident with completion: FRAME_VLD stays 1 and OVR stays 0.
- Reset mid-frame: RST asserted after 2 of 4 digits are captured.
  - Required: all outputs return to 0, and the next frame needs all 4 digits again.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared 7-segment definitions. The digit pattern table is the
//                single source for both the board decoder and the capture-side
//                encoder, so encode and decode cannot drift apart.
//                Segment order is S[6]=a ... S[0]=g, active-high.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // Patterns for digits 0..9 as produced by the board's BCD-to-segment decoder.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011   // 9
  };

  // Nibble reported for any pattern outside the table.
  localparam logic [3:0] BCD_INVALID = 4'hF;

  // Capture FSM encoding.
  typedef enum logic [0:0] {
    ST_SAMPLE = 1'b0,
    ST_HOLD   = 1'b1
  } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/enc7seg.sv
`default_nettype none
// ============================================================================
//  Module      : enc7seg
//  Description : Combinational inverse of the board's BCD-to-segment decoder.
//                Maps a 7-bit segment pattern back to its BCD digit.
//  Ports       : seg_i [6:0]  segment pattern (S[6]=a ... S[0]=g)
//                bcd_o [3:0]  decoded digit, BCD_INVALID when unrecognised
//                err_o        1 when the pattern is not one of the ten digits
//  Revision    : 1.0  initial release
// ============================================================================
module enc7seg
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  always_comb begin
    bcd_o = BCD_INVALID;
    err_o = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (seg_i == SEG_DIGIT[k]) begin
        bcd_o = 4'(k);
        err_o = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/scan7seg.sv
`default_nettype none
// ============================================================================
//  Module      : scan7seg
//  Description : Capture block for a multiplexed 7-segment display bus.
//                Qualifies each (segments, strobe) pair for STABLE cycles,
//                decodes it back to BCD, collects one nibble per digit and
//                presents the complete frame through a valid/ack handshake.
//  Ports       : CLK, RST            clock, synchronous active-high reset
//                S [6:0]             segment lines
//                DIG [NDIG-1:0]      one-hot digit strobes
//                FRAME_ACK           consumer accepts the current frame
//                BCD_OUT [4*NDIG-1:0] frame digits, digit i at [4i+3:4i]
//                ERR [NDIG-1:0]      per-digit invalid-pattern flags
//                FRAME_VLD           frame available
//                OVR                 sticky overrun (frame replaced unread)
//  Revision    : 1.0  initial release
// ============================================================================
module scan7seg
  import seg7_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [6:0]        S,
  input  logic [NDIG-1:0]   DIG,
  input  logic              FRAME_ACK,
  output logic [4*NDIG-1:0] BCD_OUT,
  output logic [NDIG-1:0]   ERR,
  output logic              FRAME_VLD,
  output logic              OVR
);

  logic [6:0]        s_q;
  logic [NDIG-1:0]   dig_q;
  logic [7:0]        cnt_q;
  cap_state_e        state_q;
  logic [NDIG-1:0]   got_q,      got_d;
  logic [4*NDIG-1:0] slot_q,     slot_d;
  logic [NDIG-1:0]   slot_err_q, slot_err_d;
  logic [4*NDIG-1:0] bcd_q;
  logic [NDIG-1:0]   err_q;
  logic              vld_q;
  logic              ovr_q;

  logic [3:0]        w_bcd;
  logic              w_err;
  logic              w_match;
  logic              w_capture;
  logic              w_complete;

  enc7seg u_enc (
    .seg_i (s_q),
    .bcd_o (w_bcd),
    .err_o (w_err)
  );

  assign w_match = (S == s_q) && (DIG == dig_q);

  // Non-one-hot strobes (blanking, overlapping strobes) are never captured.
  assign w_capture = (state_q == ST_SAMPLE) && w_match && $onehot(dig_q) &&
                     (cnt_q == 8'(STABLE - 1));

  // Working-slot update; the frame copy below uses these next values so the
  // last digit of a frame lands in the output on the same edge.
  always_comb begin
    got_d      = got_q;
    slot_d     = slot_q;
    slot_err_d = slot_err_q;
    if (w_capture) begin
      got_d = got_q | dig_q;
      for (int i = 0; i < NDIG; i++) begin
        if (dig_q[i]) begin
          slot_d[4*i +: 4] = w_bcd;
          slot_err_d[i]    = w_err;
        end
      end
    end
  end

  assign w_complete = w_capture && (&got_d);

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_q        <= '0;
      dig_q      <= '0;
      cnt_q      <= '0;
      state_q    <= ST_SAMPLE;
      got_q      <= '0;
      slot_q     <= '0;
      slot_err_q <= '0;
      bcd_q      <= '0;
      err_q      <= '0;
      vld_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      s_q   <= S;
      dig_q <= DIG;

      // Saturate so a very long hold cannot wrap back onto STABLE-1.
      if (!w_match)            cnt_q <= '0;
      else if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;

      case (state_q)
        ST_SAMPLE: if (w_capture) state_q <= ST_HOLD;
        ST_HOLD:   if (!w_match)  state_q <= ST_SAMPLE;
        default:                  state_q <= ST_SAMPLE;
      endcase

      got_q      <= w_complete ? '0 : got_d;
      slot_q     <= slot_d;
      slot_err_q <= slot_err_d;

      if (w_complete) begin
        bcd_q <= slot_d;
        err_q <= slot_err_d;
        vld_q <= 1'b1;
        // An ACK on the completion edge consumes the old frame, so no overrun.
        if (vld_q && FRAME_ACK)  ovr_q <= 1'b0;
        else if (vld_q)          ovr_q <= 1'b1;
      end else if (vld_q && FRAME_ACK) begin
        vld_q <= 1'b0;
        ovr_q <= 1'b0;
      end
    end
  end

  assign BCD_OUT   = bcd_q;
  assign ERR       = err_q;
  assign FRAME_VLD = vld_q;
  assign OVR       = ovr_q;

endmodule
`default_nettype wire
